// File: rtl/stim_pkg.sv
// stim_pkg: shared types and constants for the stimulus sequencer.
//   state_t       : sequencer states (IDLE, RUN, DONE)
//   KEY_RELEASED  : default KEY value, all keys released (active-low)
//   stim_entry_t  : one stimulus table entry {sw, key, exp, mask, dwell}
// The STIM_*_W widths size the entry struct and are the default widths
// of the sequencer parameters; the two must stay in step.
package stim_pkg;

    localparam int unsigned STIM_SW_W    = 18;
    localparam int unsigned STIM_KEY_W   = 4;
    localparam int unsigned STIM_OBS_W   = 18;
    localparam int unsigned STIM_DWELL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [STIM_KEY_W-1:0] KEY_RELEASED = '1;

    typedef struct packed {
        logic [STIM_SW_W-1:0]    sw;
        logic [STIM_KEY_W-1:0]   key;
        logic [STIM_OBS_W-1:0]   exp;
        logic [STIM_OBS_W-1:0]   mask;
        logic [STIM_DWELL_W-1:0] dwell;
    } stim_entry_t;

endpackage

// File: rtl/stim_table.sv
// stim_table: DEPTH-entry stimulus register file.
//   clk, rst_n : clock, asynchronous active-low clear of all entries
//   we, waddr, wdata : synchronous write port
//   raddr, rdata     : combinational read port
module stim_table
    import stim_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  stim_entry_t              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output stim_entry_t              rdata
);

    stim_entry_t mem_q [DEPTH];
    stim_entry_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/stim_sequencer.sv
// stim_sequencer: replays a programmed table of switch/key stimulus,
// holding each entry for its dwell time and checking the observed output
// against a masked expected value in the final dwell cycle of each entry.
//   CLOCK_50, rst_n       : clock, asynchronous active-low reset
//   wr_*                  : table programming port (accepted only in IDLE)
//   loop_en, start, abort : run control
//   obs                   : device output under test
//   SW, KEY               : driven stimulus (defaults 0 / all released)
//   busy, done, step_idx  : run status; done pulses once at completion
//   mismatch_cnt          : saturating count of failed checks
module stim_sequencer
    import stim_pkg::*;
#(
    parameter int unsigned SW_W    = STIM_SW_W,
    parameter int unsigned KEY_W   = STIM_KEY_W,
    parameter int unsigned OBS_W   = STIM_OBS_W,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DWELL_W = STIM_DWELL_W
) (
    input  logic                     CLOCK_50,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [SW_W-1:0]          wr_sw,
    input  logic [KEY_W-1:0]         wr_key,
    input  logic [OBS_W-1:0]         wr_exp,
    input  logic [OBS_W-1:0]         wr_mask,
    input  logic [DWELL_W-1:0]       wr_dwell,
    input  logic                     wr_last,
    input  logic                     loop_en,
    input  logic                     start,
    input  logic                     abort,
    input  logic [OBS_W-1:0]         obs,
    output logic [SW_W-1:0]          SW,
    output logic [KEY_W-1:0]         KEY,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic [7:0]               mismatch_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_t             state_q, state_d;
    logic [SW_W-1:0]    sw_q, sw_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [AW-1:0]      step_q, step_d;
    logic [AW-1:0]      last_q, last_d;
    logic [7:0]         mis_q, mis_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [OBS_W-1:0]   exp_q, exp_d;
    logic [OBS_W-1:0]   mask_q, mask_d;

    logic               tbl_we;
    stim_entry_t        wr_entry;
    stim_entry_t        rd_entry;
    logic [AW-1:0]      rd_addr;
    logic               is_last;
    logic [AW-1:0]      next_idx;
    logic               mis_hit;

    assign tbl_we = wr_en && (state_q == ST_IDLE);

    always_comb begin
        wr_entry       = '0;
        wr_entry.sw    = wr_sw;
        wr_entry.key   = wr_key;
        wr_entry.exp   = wr_exp;
        wr_entry.mask  = wr_mask;
        wr_entry.dwell = wr_dwell;
    end

    stim_table #(.DEPTH(DEPTH)) u_table (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .we    (tbl_we),
        .waddr (wr_addr),
        .wdata (wr_entry),
        .raddr (rd_addr),
        .rdata (rd_entry)
    );

    // The single read port always prefetches the entry to load next;
    // the current entry's exp/mask are captured when it is loaded.
    assign is_last  = (step_q == last_q) || (step_q == '1);
    assign next_idx = is_last ? '0 : step_q + AW'(1);
    assign rd_addr  = (state_q == ST_RUN) ? next_idx : '0;
    assign mis_hit  = ((obs ^ exp_q) & mask_q) != '0;

    always_comb begin
        state_d = state_q;
        sw_d    = sw_q;
        key_d   = key_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        step_d  = step_q;
        last_d  = last_q;
        mis_d   = mis_q;
        dwell_d = dwell_q;
        exp_d   = exp_q;
        mask_d  = mask_q;

        if (tbl_we && wr_last) begin
            last_d = wr_addr;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    step_d  = '0;
                    mis_d   = '0;
                    sw_d    = rd_entry.sw;
                    key_d   = rd_entry.key;
                    exp_d   = rd_entry.exp;
                    mask_d  = rd_entry.mask;
                    dwell_d = (rd_entry.dwell == '0) ? '0 : rd_entry.dwell - DWELL_W'(1);
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    sw_d    = '0;
                    key_d   = KEY_RELEASED;
                end else if (dwell_q != '0) begin
                    dwell_d = dwell_q - DWELL_W'(1);
                end else begin
                    if (mis_hit && (mis_q != 8'hFF)) begin
                        mis_d = mis_q + 8'd1;
                    end
                    if (is_last && !loop_en) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        sw_d    = '0;
                        key_d   = KEY_RELEASED;
                    end else begin
                        step_d  = next_idx;
                        sw_d    = rd_entry.sw;
                        key_d   = rd_entry.key;
                        exp_d   = rd_entry.exp;
                        mask_d  = rd_entry.mask;
                        dwell_d = (rd_entry.dwell == '0) ? '0 : rd_entry.dwell - DWELL_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sw_q    <= '0;
            key_q   <= KEY_RELEASED;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            step_q  <= '0;
            last_q  <= '0;
            mis_q   <= '0;
            dwell_q <= '0;
            exp_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            sw_q    <= sw_d;
            key_q   <= key_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            step_q  <= step_d;
            last_q  <= last_d;
            mis_q   <= mis_d;
            dwell_q <= dwell_d;
            exp_q   <= exp_d;
            mask_q  <= mask_d;
        end
    end

    assign SW           = sw_q;
    assign KEY          = key_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign step_idx     = step_q;
    assign mismatch_cnt = mis_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Bench for stim_sequencer: a reference model expands the programmed table
// into the expected per-cycle output trace, which is queued at start; a
// monitor pops one expectation for every cycle the DUT shows busy or done.
module tb_stim_sequencer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [17:0] wr_sw;
    logic [3:0]  wr_key;
    logic [17:0] wr_exp;
    logic [17:0] wr_mask;
    logic [15:0] wr_dwell;
    logic        wr_last;
    logic        loop_en;
    logic        start;
    logic        abort;
    logic [17:0] obs;
    logic [17:0] SW;
    logic [3:0]  KEY;
    logic        busy;
    logic        done;
    logic [3:0]  step_idx;
    logic [7:0]  mismatch_cnt;

    always #5 clk = ~clk;

    stim_sequencer #(.SW_W(18), .KEY_W(4), .OBS_W(18), .DEPTH(16), .DWELL_W(16)) dut (
        .CLOCK_50     (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_sw        (wr_sw),
        .wr_key       (wr_key),
        .wr_exp       (wr_exp),
        .wr_mask      (wr_mask),
        .wr_dwell     (wr_dwell),
        .wr_last      (wr_last),
        .loop_en      (loop_en),
        .start        (start),
        .abort        (abort),
        .obs          (obs),
        .SW           (SW),
        .KEY          (KEY),
        .busy         (busy),
        .done         (done),
        .step_idx     (step_idx),
        .mismatch_cnt (mismatch_cnt)
    );

    // device-under-test stand-in: observed value depends on the applied entry
    logic [17:0] obs_tab [DEPTH];
    assign obs = obs_tab[step_idx];

    // reference copy of the table
    logic [17:0] m_sw   [DEPTH];
    logic [3:0]  m_key  [DEPTH];
    logic [17:0] m_exp  [DEPTH];
    logic [17:0] m_mask [DEPTH];
    int          m_dwell[DEPTH];
    int          m_last;
    int          exp_mis;

    typedef struct {
        logic [17:0] sw;
        logic [3:0]  key;
        int          step;
        bit          busy;
        bit          done;
        int          mis;
    } item_t;

    item_t exp_q[$];
    int    vectors    = 0;
    int    miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_sw[i] = '0; m_key[i] = '0; m_exp[i] = '0; m_mask[i] = '0; m_dwell[i] = 0;
        end
        m_last = 0;
    endtask

    // Expand the table into the expected trace; abort_after>0 stops after
    // that many busy cycles (the aborted cycle performs no check).
    task automatic build_trace(input bit lp, input int abort_after);
        int    step = 0;
        int    m    = 0;
        int    n    = 0;
        int    d;
        bit    fin  = 0;
        item_t it;
        while (!fin && n < 4000) begin
            d = (m_dwell[step] == 0) ? 1 : m_dwell[step];
            for (int c = 0; c < d && !fin; c++) begin
                n++;
                it.sw = m_sw[step]; it.key = m_key[step]; it.step = step;
                it.busy = 1; it.done = 0; it.mis = m;
                exp_q.push_back(it);
                if (abort_after != 0 && n == abort_after) begin
                    fin = 1;
                end else if (c == d - 1) begin
                    if ((((obs_tab[step] ^ m_exp[step]) & m_mask[step]) != 0) && m < 255) m++;
                    if (step == m_last || step == DEPTH - 1) begin
                        if (lp) begin
                            step = 0;
                        end else begin
                            it.sw = '0; it.key = 4'hF; it.step = 0;
                            it.busy = 0; it.done = 1; it.mis = m;
                            exp_q.push_back(it);
                            fin = 1;
                        end
                    end else begin
                        step++;
                    end
                end
            end
        end
        exp_mis = m;
    endtask

    // monitor / scoreboard
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && (busy === 1'b1 || done === 1'b1)) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL trace_extra: got SW=%h KEY=%h busy=%b done=%b, required no output activity",
                             SW, KEY, busy, done);
                end else begin
                    it = exp_q.pop_front();
                    if (SW !== it.sw || KEY !== it.key || busy !== it.busy || done !== it.done ||
                        mismatch_cnt !== 8'(it.mis) || (it.busy && step_idx !== 4'(it.step))) begin
                        miscompares++;
                        $display("FAIL trace: got SW=%h KEY=%h step=%0d busy=%b done=%b mis=%0d, required SW=%h KEY=%h step=%0d busy=%b done=%b mis=%0d",
                                 SW, KEY, step_idx, busy, done, mismatch_cnt,
                                 it.sw, it.key, it.step, it.busy, it.done, it.mis);
                    end
                end
            end
        end
    end

    task automatic write_entry(input int addr, input logic [17:0] sw, input logic [3:0] key,
                               input logic [17:0] e, input logic [17:0] mk,
                               input int dw, input bit last);
        @(negedge clk);
        wr_en = 1; wr_addr = 4'(addr); wr_sw = sw; wr_key = key;
        wr_exp = e; wr_mask = mk; wr_dwell = 16'(dw); wr_last = last;
        @(negedge clk);
        wr_en = 0; wr_last = 0;
        m_sw[addr] = sw; m_key[addr] = key; m_exp[addr] = e; m_mask[addr] = mk; m_dwell[addr] = dw;
        if (last) m_last = addr;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_SW"},   32'(SW),   32'h0);
        chk({tag, "_KEY"},  32'(KEY),  32'hF);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
    endtask

    task automatic run_seq(input string tag, input bit lp, input int abort_after,
                           input bit mid_start, input bit mid_write);
        int k;
        int n0;
        build_trace(lp, abort_after);
        n0 = exp_q.size();
        loop_en = lp;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0; k = 1;
        while ((abort_after != 0) ? (k < abort_after) : (exp_q.size() != 0 && k < 5000)) begin
            @(negedge clk); k++;
            start = mid_start && k == 2 && n0 >= 3;
            wr_en = mid_write && k == 2 && n0 >= 3;
            if (wr_en) begin
                wr_addr = 0; wr_sw = 18'h3FFFF; wr_key = 4'h5; wr_exp = 18'h3FFFF;
                wr_mask = 18'h3FFFF; wr_dwell = 16'd7; wr_last = 1;
            end else begin
                wr_last = 0;
            end
        end
        start = 0; wr_en = 0; wr_last = 0;
        if (abort_after != 0) begin
            abort = 1;
            @(negedge clk);
            abort = 0;
        end else begin
            if (exp_q.size() != 0) begin
                vectors++; miscompares++;
                $display("FAIL %s_timeout: got %0d pending outputs, required 0", tag, exp_q.size());
            end
            @(negedge clk);
        end
        chk_idle(tag);
        chk({tag, "_mismatch_cnt"}, 32'(mismatch_cnt), 32'(exp_mis));
        if (exp_q.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL %s_leftover: got %0d unconsumed expectations, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int lst;
        bit lp;
        int ab;
        rst_n = 0; wr_en = 0; wr_addr = 0; wr_sw = 0; wr_key = 0; wr_exp = 0; wr_mask = 0;
        wr_dwell = 0; wr_last = 0; loop_en = 0; start = 0; abort = 0;
        for (int i = 0; i < DEPTH; i++) obs_tab[i] = '0;
        model_reset();
        #12;
        chk_idle("reset");
        chk("reset_step", 32'(step_idx), 32'h0);
        chk("reset_mis", 32'(mismatch_cnt), 32'h0);
        @(negedge clk); #2 rst_n = 1;

        // basic 3-entry sequence
        write_entry(0, 18'h00001, 4'hE, 18'h0, 18'h0, 2, 0);
        write_entry(1, 18'h00002, 4'hD, 18'h0, 18'h0, 3, 0);
        write_entry(2, 18'h00003, 4'hB, 18'h0, 18'h0, 1, 1);
        run_seq("basic", 0, 0, 0, 0);

        // masked compare
        write_entry(0, 18'h00010, 4'h7, 18'h0000F, 18'h0000F, 1, 1);
        obs_tab[0] = 18'h0001F;
        run_seq("mask_ok", 0, 0, 0, 0);
        obs_tab[0] = 18'h0000E;
        run_seq("mask_bad", 0, 0, 0, 0);

        // abort during entry 1 of 3
        write_entry(0, 18'h00011, 4'h1, 18'h0, 18'h0, 3, 0);
        write_entry(1, 18'h00022, 4'h2, 18'h0, 18'h0, 3, 0);
        write_entry(2, 18'h00033, 4'h3, 18'h0, 18'h0, 3, 1);
        run_seq("abort", 0, 5, 0, 0);

        // write during run ignored; dwell 0 entry
        write_entry(0, 18'h00155, 4'hA, 18'h0, 18'h0, 0, 0);
        write_entry(1, 18'h002AA, 4'h6, 18'h00100, 18'h00300, 2, 1);
        obs_tab[1] = 18'h00200;
        run_seq("run_write", 0, 0, 0, 1);
        run_seq("after_write", 0, 0, 0, 0);

        // saturation with looping, start while busy ignored
        write_entry(0, 18'h00001, 4'hE, 18'h0, 18'h3FFFF, 1, 0);
        write_entry(1, 18'h00002, 4'hD, 18'h0, 18'h3FFFF, 1, 1);
        obs_tab[0] = 18'h00001; obs_tab[1] = 18'h00002;
        run_seq("saturate", 1, 300, 1, 0);

        // randomized tables
        for (int r = 0; r < 10; r++) begin
            lst = $urandom_range(0, 5);
            for (int i = 0; i <= lst; i++) begin
                write_entry(i, 18'($urandom), 4'($urandom), 18'($urandom), 18'($urandom),
                            $urandom_range(0, 3), i == lst);
                obs_tab[i] = ($urandom_range(0, 1) == 1) ? m_exp[i] : 18'($urandom);
            end
            lp = (r % 3 == 0);
            ab = lp ? $urandom_range(5, 40) : 0;
            run_seq("random", lp, ab, r[0], 0);
        end

        // reset mid-run
        write_entry(0, 18'h00001, 4'hE, 18'h0, 18'h0, 2, 0);
        write_entry(1, 18'h00002, 4'hD, 18'h0, 18'h0, 3, 0);
        write_entry(2, 18'h00003, 4'hB, 18'h0, 18'h0, 1, 1);
        build_trace(0, 0);
        loop_en = 0;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk_idle("midreset");
        chk("midreset_step", 32'(step_idx), 32'h0);
        chk("midreset_mis", 32'(mismatch_cnt), 32'h0);
        exp_q.delete();
        model_reset();
        @(negedge clk); #2 rst_n = 1;
        @(negedge clk);
        chk_idle("post_reset");
        run_seq("zeroed_table", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
